// File: rtl/adv7513_video_timing_if.sv
`default_nettype none
// ============================================================================
// Module  : adv7513_video_timing_if
// Brief   : Fixed-latency x/y pixel request bus to an upstream frame source
// Revision: 1.0
// ============================================================================
interface adv7513_video_timing_if;
  logic        req_valid;
  logic [11:0] req_x;
  logic [11:0] req_y;
  logic [23:0] pix_data_in;

  modport master (output req_valid, req_x, req_y, input pix_data_in);
  modport slave  (input req_valid, req_x, req_y, output pix_data_in);
endinterface
`default_nettype wire

// File: rtl/adv7513_video_timing.sv
`default_nettype none
// ============================================================================
// Module  : adv7513_video_timing
// Brief   : HS/VS/DE/RGB timing generator for the ADV7513, gated by init done
// Revision: 1.0
// ============================================================================
module adv7513_video_timing #(
  parameter int H_ACTIVE    = 1280,
  parameter int H_FP        = 110,
  parameter int H_SYNC      = 40,
  parameter int H_BP        = 220,
  parameter int V_ACTIVE    = 720,
  parameter int V_FP        = 5,
  parameter int V_SYNC      = 5,
  parameter int V_BP        = 20,
  parameter int HS_POL      = 1,
  parameter int VS_POL      = 1,
  parameter int PIX_LATENCY = 2
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              i_init_done,
  input  wire logic              i_pattern_en,
  adv7513_video_timing_if.master pix_if,
  output logic                   o_vid_hs,
  output logic                   o_vid_vs,
  output logic                   o_vid_de,
  output logic [23:0]            o_vid_data,
  output logic                   o_frame_start,
  output logic                   o_running
);

  localparam int          c_H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int          c_V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int          c_BAR_W    = (H_ACTIVE / 8 < 1) ? 1 : H_ACTIVE / 8;
  localparam logic [11:0] c_H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] c_HS_BEG   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] c_HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] c_H_LAST   = 12'(c_H_TOTAL - 1);
  localparam logic [11:0] c_V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] c_VS_BEG   = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] c_VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] c_V_LAST   = 12'(c_V_TOTAL - 1);
  localparam logic [11:0] c_BAR_LAST = 12'(c_BAR_W - 1);
  localparam logic        c_HS_ON    = 1'(HS_POL);
  localparam logic        c_VS_ON    = 1'(VS_POL);
  localparam int          c_PW       = 29;

  localparam logic [1:0] c_S_IDLE = 2'd0;
  localparam logic [1:0] c_S_RUN  = 2'd1;
  localparam logic [1:0] c_S_STOP = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic        w_active;
  logic [11:0] r_h_cnt;
  logic [11:0] r_v_cnt;
  logic [11:0] r_bar_pix;
  logic [3:0]  r_bar_idx;
  logic        r_pattern;
  logic        w_h_wrap;
  logic        w_frame_end;
  logic        w_origin;
  logic        w_req;
  logic        w_hs;
  logic        w_vs;
  logic        w_pat_sel;
  logic [23:0] w_bar_col;
  logic        r_req_valid;
  logic [11:0] r_req_x;
  logic [11:0] r_req_y;
  logic [c_PW-1:0] r_pipe [PIX_LATENCY];
  logic        w_t_hs;
  logic        w_t_vs;
  logic        w_t_de;
  logic        w_t_first;
  logic        w_t_pat;
  logic [23:0] w_t_col;
  logic        r_vid_hs;
  logic        r_vid_vs;
  logic        r_vid_de;
  logic [23:0] r_vid_data;
  logic        r_frame_start;

  assign w_h_wrap    = (r_h_cnt == c_H_LAST);
  assign w_frame_end = w_h_wrap && (r_v_cnt == c_V_LAST);
  assign w_origin    = (r_h_cnt == 12'd0) && (r_v_cnt == 12'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= c_S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // STOP prefers resuming RUN over retiring, so a late init_done never drops a frame
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_S_IDLE: if (i_init_done) w_state_nxt = c_S_RUN;
      c_S_RUN:  if (!i_init_done) w_state_nxt = c_S_STOP;
      c_S_STOP: begin
        if (i_init_done)      w_state_nxt = c_S_RUN;
        else if (w_frame_end) w_state_nxt = c_S_IDLE;
      end
      default:  w_state_nxt = c_S_IDLE;
    endcase
  end

  always_comb begin
    w_active = (r_state == c_S_RUN) || (r_state == c_S_STOP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_h_cnt   <= '0;
      r_v_cnt   <= '0;
      r_bar_pix <= '0;
      r_bar_idx <= '0;
    end else if (!w_active) begin
      r_h_cnt   <= '0;
      r_v_cnt   <= '0;
      r_bar_pix <= '0;
      r_bar_idx <= '0;
    end else if (w_h_wrap) begin
      r_h_cnt   <= '0;
      r_v_cnt   <= (r_v_cnt == c_V_LAST) ? 12'd0 : r_v_cnt + 12'd1;
      r_bar_pix <= '0;
      r_bar_idx <= '0;
    end else begin
      r_h_cnt <= r_h_cnt + 12'd1;
      if (r_bar_pix == c_BAR_LAST) begin
        r_bar_pix <= '0;
        if (r_bar_idx != 4'd8) r_bar_idx <= r_bar_idx + 4'd1;
      end else begin
        r_bar_pix <= r_bar_pix + 12'd1;
      end
    end
  end

  assign w_req     = w_active && (r_h_cnt < c_H_ACT) && (r_v_cnt < c_V_ACT);
  assign w_hs      = w_active && (r_h_cnt >= c_HS_BEG) && (r_h_cnt < c_HS_END);
  assign w_vs      = w_active && (r_v_cnt >= c_VS_BEG) && (r_v_cnt < c_VS_END);
  assign w_pat_sel = w_origin ? i_pattern_en : r_pattern;

  always_comb begin
    w_bar_col = 24'h000000;
    case (r_bar_idx)
      4'd0: w_bar_col = 24'hFFFFFF;
      4'd1: w_bar_col = 24'hFFFF00;
      4'd2: w_bar_col = 24'h00FFFF;
      4'd3: w_bar_col = 24'h00FF00;
      4'd4: w_bar_col = 24'hFF00FF;
      4'd5: w_bar_col = 24'hFF0000;
      4'd6: w_bar_col = 24'h0000FF;
      default: w_bar_col = 24'h000000;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pattern   <= 1'b0;
      r_req_valid <= 1'b0;
      r_req_x     <= '0;
      r_req_y     <= '0;
      r_pipe[0]   <= '0;
    end else begin
      r_pattern   <= w_pat_sel;
      r_req_valid <= w_req;
      r_req_x     <= w_req ? r_h_cnt : 12'd0;
      r_req_y     <= w_req ? r_v_cnt : 12'd0;
      r_pipe[0]   <= {w_hs, w_vs, w_req, w_req && w_origin, w_pat_sel, w_bar_col};
    end
  end

  // Stage 0 is the request stage; the output register supplies the final clock of latency
  for (genvar gi = 1; gi < PIX_LATENCY; gi++) begin : g_dly
    always_ff @(posedge clk or posedge reset) begin
      if (reset) r_pipe[gi] <= '0;
      else       r_pipe[gi] <= r_pipe[gi-1];
    end
  end

  assign {w_t_hs, w_t_vs, w_t_de, w_t_first, w_t_pat, w_t_col} = r_pipe[PIX_LATENCY-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vid_hs      <= ~c_HS_ON;
      r_vid_vs      <= ~c_VS_ON;
      r_vid_de      <= 1'b0;
      r_vid_data    <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_vid_hs      <= w_t_hs ? c_HS_ON : ~c_HS_ON;
      r_vid_vs      <= w_t_vs ? c_VS_ON : ~c_VS_ON;
      r_vid_de      <= w_t_de;
      r_vid_data    <= !w_t_de ? 24'h000000 : (w_t_pat ? w_t_col : pix_if.pix_data_in);
      r_frame_start <= w_t_first;
    end
  end

  assign pix_if.req_valid = r_req_valid;
  assign pix_if.req_x     = r_req_x;
  assign pix_if.req_y     = r_req_y;
  assign o_vid_hs         = r_vid_hs;
  assign o_vid_vs         = r_vid_vs;
  assign o_vid_de         = r_vid_de;
  assign o_vid_data       = r_vid_data;
  assign o_frame_start    = r_frame_start;
  assign o_running        = w_active;

endmodule
`default_nettype wire

// File: tb/tb_adv7513_video_timing.sv
`default_nettype none
// ============================================================================
// Module  : tb_adv7513_video_timing
// Brief   : Reference-model bench for the ADV7513 video timing generator
// Revision: 1.0
// ============================================================================
module tb_adv7513_video_timing;

  localparam int HA = 8, HF = 2, HSW = 2, HB = 2;
  localparam int VA = 4, VF = 1, VSW = 1, VB = 1;
  localparam int LAT = 2;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int FRAME = HT * VT;
  localparam int BARW = HA / 8;
  localparam bit HSP = 1'b1;
  localparam bit VSP = 1'b1;

  typedef struct {
    bit          v;
    bit          hs;
    bit          vs;
    int          x;
    int          y;
    bit          pat;
    logic [23:0] col;
  } bund_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        init_done = 1'b0;
  logic        pattern_en = 1'b0;
  logic        vid_hs, vid_vs, vid_de, frame_start, running;
  logic [23:0] vid_data;

  bund_t       exp_q[$];
  logic [24:0] src_q[$];
  int          mstate;
  int          pos;
  bit          mpat;
  int          n_assert = 0;
  int          n_fail = 0;
  logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  always #5 clk = ~clk;

  adv7513_video_timing_if bus ();

  adv7513_video_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(1), .VS_POL(1), .PIX_LATENCY(LAT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_init_done   (init_done),
    .i_pattern_en  (pattern_en),
    .pix_if        (bus),
    .o_vid_hs      (vid_hs),
    .o_vid_vs      (vid_vs),
    .o_vid_de      (vid_de),
    .o_vid_data    (vid_data),
    .o_frame_start (frame_start),
    .o_running     (running)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    bund_t idle;
    idle = '{v: 0, hs: 0, vs: 0, x: 0, y: 0, pat: 0, col: 24'h0};
    mstate = 0;
    pos    = 0;
    mpat   = 0;
    exp_q.delete();
    for (int i = 0; i <= LAT; i++) exp_q.push_back(idle);
    src_q.delete();
    for (int i = 0; i < LAT - 1; i++) src_q.push_back(25'h0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_valid"}, 32'(bus.req_valid), 32'(0));
    check({tag, "_req_x"}, 32'(bus.req_x), 32'(0));
    check({tag, "_req_y"}, 32'(bus.req_y), 32'(0));
    check({tag, "_vid_hs"}, 32'(vid_hs), 32'(!HSP));
    check({tag, "_vid_vs"}, 32'(vid_vs), 32'(!VSP));
    check({tag, "_vid_de"}, 32'(vid_de), 32'(0));
    check({tag, "_vid_data"}, 32'(vid_data), 32'(0));
    check({tag, "_frame_start"}, 32'(frame_start), 32'(0));
    check({tag, "_running"}, 32'(running), 32'(0));
  endtask

  // One clock: predict from frame position, advance, then compare every output
  task automatic tick();
    bund_t       nb;
    bund_t       e;
    int          h, v, b, nstate;
    logic [24:0] s;
    logic [23:0] ed;
    h = pos % HT;
    v = pos / HT;
    nb.pat = (pos == 0) ? pattern_en : mpat;
    mpat   = nb.pat;
    nb.v   = (mstate != 0) && (h < HA) && (v < VA);
    nb.hs  = (mstate != 0) && (h >= HA + HF) && (h < HA + HF + HSW);
    nb.vs  = (mstate != 0) && (v >= VA + VF) && (v < VA + VF + VSW);
    nb.x   = h;
    nb.y   = v;
    b      = h / BARW;
    nb.col = 24'h0;
    if (b < 8) nb.col = bar_tab[b];
    case (mstate)
      0:       nstate = init_done ? 1 : 0;
      1:       nstate = init_done ? 1 : 2;
      default: nstate = init_done ? 1 : ((pos == FRAME - 1) ? 0 : 2);
    endcase
    pos    = (mstate == 0) ? 0 : (pos + 1) % FRAME;
    mstate = nstate;

    @(posedge clk);
    #1;
    exp_q.push_back(nb);
    void'(exp_q.pop_front());
    s = src_q.pop_front();
    bus.pix_data_in = s[24] ? s[23:0] : 24'($urandom);
    src_q.push_back({bus.req_valid, bus.req_y, bus.req_x});

    check("req_valid", 32'(bus.req_valid), 32'(nb.v));
    check("req_x", 32'(bus.req_x), nb.v ? 32'(nb.x) : 32'(0));
    check("req_y", 32'(bus.req_y), nb.v ? 32'(nb.y) : 32'(0));
    check("running", 32'(running), 32'(mstate != 0));
    e  = exp_q[0];
    ed = 24'h0;
    if (e.v) ed = e.pat ? e.col : {12'(e.y), 12'(e.x)};
    check("vid_de", 32'(vid_de), 32'(e.v));
    check("vid_hs", 32'(vid_hs), 32'(e.hs ? HSP : !HSP));
    check("vid_vs", 32'(vid_vs), 32'(e.vs ? VSP : !VSP));
    check("vid_data", 32'(vid_data), 32'(ed));
    check("frame_start", 32'(frame_start), 32'(e.v && e.x == 0 && e.y == 0));
  endtask

  initial begin
    int fs_ticks[$];
    int first_req, first_de, de_cnt, vs_cnt, cnt, all_run;

    bus.pix_data_in = 24'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    reset = 1'b0;

    // Startup gating
    repeat (50) tick();
    check("gated_running", 32'(running), 32'(0));

    // Three frames from upstream source
    init_done = 1'b1;
    first_req = -1;
    first_de  = -1;
    de_cnt    = 0;
    vs_cnt    = 0;
    for (int t = 1; t <= 3 * FRAME; t++) begin
      tick();
      if (t == 1) check("running_next_clk", 32'(running), 32'(1));
      if (bus.req_valid && first_req < 0) first_req = t;
      if (vid_de && first_de < 0) first_de = t;
      if (vid_de) de_cnt++;
      if (vid_vs == VSP) vs_cnt++;
      if (frame_start) fs_ticks.push_back(t);
    end
    check("de_after_req", 32'(first_de - first_req), 32'(LAT));
    check("de_clocks_3frames", 32'(de_cnt), 32'(3 * HA * VA));
    check("vs_clocks_3frames", 32'(vs_cnt), 32'(3 * VSW * HT));
    check("frame_start_count", 32'(fs_ticks.size()), 32'(3));
    if (fs_ticks.size() == 3) begin
      check("frame_period_1", 32'(fs_ticks[1] - fs_ticks[0]), 32'(FRAME));
      check("frame_period_2", 32'(fs_ticks[2] - fs_ticks[1]), 32'(FRAME));
    end

    // Colour bars, then random pattern_en changes only honoured at frame start
    pattern_en = 1'b1;
    repeat (2 * FRAME) tick();
    for (int t = 0; t < 2 * FRAME; t++) begin
      if ($urandom_range(0, 19) == 0) pattern_en = ~pattern_en;
      tick();
    end

    // Graceful stop from line 1
    pattern_en = 1'b0;
    for (int i = 0; i < 2 * FRAME && !(mstate == 1 && pos == HT); i++) tick();
    init_done = 1'b0;
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (running && cnt < 3 * FRAME);
    check("stop_clocks", 32'(cnt), 32'(FRAME - HT));
    repeat (20) tick();

    // Stop then resume mid-frame
    init_done = 1'b1;
    for (int i = 0; i < 2 * FRAME && !(mstate == 1 && pos == HT); i++) tick();
    init_done = 1'b0;
    all_run = 1;
    cnt = $urandom_range(5, 60);
    for (int i = 0; i < cnt; i++) begin
      tick();
      if (!running) all_run = 0;
    end
    init_done  = 1'b1;
    pattern_en = 1'($urandom_range(0, 1));
    for (int i = 0; i < FRAME + 20; i++) begin
      tick();
      if (!running) all_run = 0;
    end
    check("resume_no_gap", 32'(all_run), 32'(1));

    // Asynchronous reset mid active line
    for (int i = 0; i < 2 * FRAME && !(mstate == 1 && pos == HT + 3); i++) tick();
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("async_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    repeat (FRAME + 10) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adv7513_video_timing.md
Name: adv7513_video_timing

Overview:
- Generates the parallel video stream (HSYNC, VSYNC, DE, 24-bit RGB) driven into the ADV7513 transmitter pins.
- Consumes the `done` flag of the ADV7513 I2C init sequencer; no video is emitted until the transmitter is configured.
- Requests pixels from an upstream frame source with a fixed-latency x/y request interface; an internal colour-bar generator can substitute for the source.
- Output format is 24-bit RGB 4:4:4 with separate syncs, matching registers 0x15/0x16 as programmed by the init sequencer.

Parameters:
- H_ACTIVE, 1280, active pixels per line
- H_FP, 110, horizontal front porch (clocks)
- H_SYNC, 40, HSYNC width (clocks)
- H_BP, 220, horizontal back porch (clocks)
- V_ACTIVE, 720, active lines per frame
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, VSYNC width (lines)
- V_BP, 20, vertical back porch (lines)
- HS_POL, 1, HSYNC active level
- VS_POL, 1, VSYNC active level
- PIX_LATENCY, 2, clocks from request to pix_data_in valid; legal range 1..8

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- init_done  in  1  ADV7513 init complete (sequencer `done`)
- pattern_en  in  1  1 = internal colour bars, 0 = pix_data_in
- pix_data_in  in  24  upstream pixel {R,G,B}, valid PIX_LATENCY clocks after req_valid
- req_valid  out  1  pixel request (active region)
- req_x  out  12  requested column
- req_y  out  12  requested row
- vid_hs  out  1  HSYNC to ADV7513
- vid_vs  out  1  VSYNC to ADV7513
- vid_de  out  1  data enable to ADV7513
- vid_data  out  24  pixel data to ADV7513
- frame_start  out  1  one-clock pulse aligned with first active pixel on vid_de
- running  out  1  timing generator in RUN or STOP state

Behaviour:
- Reset: all outputs 0, except vid_hs = ~HS_POL and vid_vs = ~VS_POL. State = IDLE; counters = 0; pipeline cleared.
- Counters: h_cnt runs 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. v_cnt runs 0..V_TOTAL-1 and increments when h_cnt wraps. Both are 12 bits wide.
- Region order, both axes: active, then front porch, then sync, then back porch.
  - Active: h_cnt < H_ACTIVE.
  - HSYNC asserted for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - VSYNC uses the same rule on v_cnt, asserted for whole lines.
- Request interface:
  - req_valid = 1 in RUN/STOP when h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
  - req_x = h_cnt and req_y = v_cnt while req_valid = 1; both are 0 otherwise.
  - req_valid, req_x and req_y are all registered together.
- Output alignment:
  - vid_hs, vid_vs and vid_de are the request-stage sync/active flags delayed by a PIX_LATENCY-stage shift register.
  - vid_data is registered in the same cycle that pix_data_in is sampled.
  - Net effect: vid_* for a given pixel appear exactly PIX_LATENCY clocks after its req_valid.
  - vid_data = 0 whenever vid_de = 0.
- Colour bars (pattern_en = 1):
  - BAR_W = H_ACTIVE/8, integer division.
  - Bar index is computed at the request stage via a bar counter that resets at h_cnt = 0 and advances every BAR_W pixels.
  - Bar colours in order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - Columns beyond 8*BAR_W use 000000.
  - Pattern data is delayed PIX_LATENCY clocks to stay aligned.
  - pattern_en is sampled at frame boundaries only (h_cnt = 0, v_cnt = 0).
- State machine:
  - IDLE: counters held at 0, outputs inactive. Goes to RUN on the first clock with init_done = 1.
  - RUN: counters free-run. If init_done = 0 is sampled, go to STOP.
  - STOP: finish the current frame. When the last clock of the frame completes (h_cnt = H_TOTAL-1, v_cnt = V_TOTAL-1), return to IDLE. If init_done returns to 1 before the frame ends, go back to RUN with no glitch.
- frame_start: pulses on the clock where vid_de first rises in a frame, i.e. pixel (0,0).
- running = 1 in RUN and STOP.
- Pipeline drain: after returning to IDLE, the delay stages flush naturally, so the last PIX_LATENCY output cycles still follow the final frame's syncs.
- Reset mid-frame: takes effect immediately (asynchronous); the partial frame is discarded.

Test Plan:
Common bench parameters: H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2 (H_TOTAL=14); V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL=7); PIX_LATENCY=2. One frame = 98 clocks.
- Startup gating: init_done held 0 for 50 clocks -> req_valid=0, vid_de=0, running=0. Raise init_done -> running=1 next clock; first req_valid with req_x=0, req_y=0; vid_de and frame_start rise exactly 2 clocks later.
- Timing geometry: run 3 frames -> vid_de high 8 clocks per active line for 4 lines/frame; vid_hs high 2 clocks starting 10 clocks after line start; vid_vs high for exactly 14 clocks per frame; frame_start period 98 clocks.
- Upstream alignment: pattern_en=0, model returns {req_y,req_x} 2 clocks after the request -> every vid_de cycle shows the matching coordinate; vid_data=0 outside DE.
- Colour bars: pattern_en=1 (BAR_W=1) -> vid_data sequence across an active line: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
- Graceful stop: drop init_done at line 1 of a frame -> current frame completes, running falls after the 98th clock, no further req_valid. Re-assert init_done mid-frame while in STOP -> frame continues seamlessly.
- Async reset: assert reset mid-active-line for 1 clock -> outputs go to reset values without waiting for a clock edge; after reset release with init_done=1, a fresh frame starts at (0,0).
